tag_compute_seq: RTL

//  Upstream stage of the tag sort circuit. Accepts one packet arrival at a time and computes its WFQ finish tag:

---
 rtl/tag_compute_seq.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/tag_compute_seq.sv
// -----------------------------------------------------------------------------
// tag_compute_seq
//   Upstream stage of the tag sort circuit. Accepts one packet arrival at a
//   time, computes its WFQ finish tag
//     finish = max(vt, last_finish[flow]) + len*weight[flow]  (saturating)
//   and sequences the sort circuit: ena1 for TREE_LAT cycles (tree pipeline),
//   then a one-cycle ena2 (table read / storage write), then waits for
//   wr_done_mem. Tracks storage occupancy and virtual time, and applies
//   backpressure when storage is full.
//
// Ports
//   clk, rst (async, active-low)
//   pkt_valid/pkt_ready, pkt_flow, pkt_len, pkt_id, pkt_spb_addr : arrival
//   cfg_we, cfg_flow, cfg_weight   : per-flow weight write
//   deq_valid, deq_tag             : storage released its minimum tag
//   wr_done_mem                    : storage write complete
//   ena1, ena2                     : sort circuit enables (registered)
//   incoming_tag, pck_id_in, pck_spb_addr_in : registered packet data out
//   occupancy, vt, err_timeout     : status
// -----------------------------------------------------------------------------
module tag_compute_seq #(
  parameter int T        = 12,
  parameter int S        = 8,
  parameter int M        = 4,
  parameter int I        = 4,
  parameter int F        = 2,
  parameter int L        = 8,
  parameter int W        = 4,
  parameter int TREE_LAT = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pkt_valid,
  output logic         pkt_ready,
  input  logic [F-1:0] pkt_flow,
  input  logic [L-1:0] pkt_len,
  input  logic [I-1:0] pkt_id,
  input  logic [S-1:0] pkt_spb_addr,
  input  logic         cfg_we,
  input  logic [F-1:0] cfg_flow,
  input  logic [W-1:0] cfg_weight,
  input  logic         deq_valid,
  input  logic [T-1:0] deq_tag,
  input  logic         wr_done_mem,
  output logic         ena1,
  output logic         ena2,
  output logic [T-1:0] incoming_tag,
  output logic [I-1:0] pck_id_in,
  output logic [S-1:0] pck_spb_addr_in,
  output logic [M:0]   occupancy,
  output logic [T-1:0] vt,
  output logic         err_timeout
);

  localparam int NF      = 2 ** F;
  localparam int PW      = L + W;
  localparam int SW      = ((PW > T) ? PW : T) + 1;
  localparam int CNT_MAX = (TREE_LAT > WAIT_MAX) ? TREE_LAT : WAIT_MAX;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [M:0] CAP = {1'b1, {M{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_TREE, S_ENA2, S_WAIT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ena1, r_ena2, r_err;
  logic [F-1:0]  r_flow;
  logic [L-1:0]  r_len;
  logic [I-1:0]  r_id;
  logic [S-1:0]  r_addr;
  logic [T-1:0]  r_tag;
  logic [I-1:0]  r_id_out;
  logic [S-1:0]  r_addr_out;
  logic [M:0]    r_occ;
  logic [T-1:0]  r_vt;
  logic [W-1:0]  r_weight      [NF];
  logic [T-1:0]  r_last_finish [NF];

  logic [T-1:0]  w_lf, w_base, w_tag;
  logic [PW-1:0] w_prod;
  logic [SW-1:0] w_sum;
  logic          w_inc, w_dec;

  // Finish-tag datapath, evaluated while in CALC from the latched arrival.
  always_comb begin
    w_lf   = r_last_finish[r_flow];
    w_base = (r_vt > w_lf) ? r_vt : w_lf;
    w_prod = PW'(r_len) * PW'(r_weight[r_flow]);
    w_sum  = SW'(w_base) + SW'(w_prod);
    w_tag  = (w_sum > SW'({T{1'b1}})) ? {T{1'b1}} : w_sum[T-1:0];
  end

  assign pkt_ready = (r_state == S_IDLE) && (r_occ < CAP);

  // Sequencer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ena1     <= 1'b0;
      r_ena2     <= 1'b0;
      r_err      <= 1'b0;
      r_flow     <= '0;
      r_len      <= '0;
      r_id       <= '0;
      r_addr     <= '0;
      r_tag      <= '0;
      r_id_out   <= '0;
      r_addr_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pkt_valid && pkt_ready) begin
            r_flow  <= pkt_flow;
            r_len   <= pkt_len;
            r_id    <= pkt_id;
            r_addr  <= pkt_spb_addr;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_tag      <= w_tag;
          r_id_out   <= r_id;
          r_addr_out <= r_addr;
          r_ena1     <= 1'b1;
          r_cnt      <= '0;
          r_state    <= S_TREE;
        end
        S_TREE: begin
          if (r_cnt == CW'(TREE_LAT - 1)) begin
            r_ena1  <= 1'b0;
            r_ena2  <= 1'b1;
            r_state <= S_ENA2;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_ENA2: begin
          r_ena2  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A write completion on the last allowed cycle still counts.
          if (wr_done_mem) begin
            r_state <= S_IDLE;
          end else if (r_cnt == CW'(WAIT_MAX - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Occupancy and virtual time. A dequeue on empty storage is ignored.
  assign w_inc = (r_state == S_WAIT) && wr_done_mem;
  assign w_dec = deq_valid && (r_occ != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ <= '0;
      r_vt  <= '0;
    end else begin
      if (w_inc && !w_dec) begin
        r_occ <= r_occ + 1'b1;
      end else if (w_dec && !w_inc) begin
        r_occ <= r_occ - 1'b1;
      end
      if (w_dec) begin
        r_vt <= deq_tag;
      end
    end
  end

  // Per-flow weight and last-finish registers.
  generate
    for (genvar gi = 0; gi < NF; gi++) begin : g_flow
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_weight[gi]      <= W'(1);
          r_last_finish[gi] <= '0;
        end else begin
          if (cfg_we && (cfg_flow == F'(gi))) begin
            r_weight[gi] <= cfg_weight;
          end
          if ((r_state == S_CALC) && (r_flow == F'(gi))) begin
            r_last_finish[gi] <= w_tag;
          end
        end
      end
    end
  endgenerate

  assign ena1            = r_ena1;
  assign ena2            = r_ena2;
  assign incoming_tag    = r_tag;
  assign pck_id_in       = r_id_out;
  assign pck_spb_addr_in = r_addr_out;
  assign occupancy       = r_occ;
  assign vt              = r_vt;
  assign err_timeout     = r_err;

endmodule
